sdram_address_sequencer: RTL and testbench

- Parametrised, clocked generator of circular-buffer SDRAM addresses with independent write and read pointers.
- Sits between the data capture path and the SDRAM controller. Provides bank/row/column for the next write and the next read, plus an occupancy count and full/empty/overflow status.
- Supports configurable address field widths, a burst step size, and a choice between overwrite-oldest and stop-when-full policies.

---
 rtl/sdram_address_sequencer.sv | 145 ++++++++++++++
 tb/tb_sdram_address_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_address_sequencer.sv
// -----------------------------------------------------------------------------
// sdram_address_sequencer
//
// Circular-buffer SDRAM address generator with independent write and read
// pointers. Each pointer is ADDR_W = BA_WIDTH+COL_WIDTH+ROW_WIDTH bits wide and
// is presented split as {BA, COL, ROW} (bank in the MSBs, row in the LSBs).
// Pointers advance by STEP per accepted strobe, modulo 2^ADDR_W. The buffer
// holds CAPACITY = 2^ADDR_W / STEP entries.
//
// Ports:
//   CLK            system clock, all state changes on the rising edge
//   RESET          synchronous active-high reset (overrides everything)
//   CLEAR          synchronous clear of pointers/count; sticky flags hold
//   NEXT_WRITE     one-cycle strobe: advance write pointer
//   NEXT_READ      one-cycle strobe: advance read pointer
//   BA/COL/ROW_WRITE_OUT  write pointer fields
//   BA/COL/ROW_READ_OUT   read pointer fields
//   COUNT          entries held, 0..CAPACITY
//   FULL / EMPTY   decodes of COUNT
//   OVERFLOW       sticky: write arrived while full
//   UNDERFLOW      sticky: read arrived while empty
//
// WRAP_MODE = 1 overwrites the oldest entry when full (the read pointer is
// dragged along); WRAP_MODE = 0 rejects writes when full.
// -----------------------------------------------------------------------------
module sdram_address_sequencer #(
   parameter int BA_WIDTH  = 2,
   parameter int ROW_WIDTH = 13,
   parameter int COL_WIDTH = 9,
   parameter int STEP      = 1,
   parameter int WRAP_MODE = 1
) (
   input  logic                                      CLK,
   input  logic                                      RESET,
   input  logic                                      CLEAR,
   input  logic                                      NEXT_WRITE,
   input  logic                                      NEXT_READ,
   output logic [BA_WIDTH-1:0]                       BA_WRITE_OUT,
   output logic [COL_WIDTH-1:0]                      COL_WRITE_OUT,
   output logic [ROW_WIDTH-1:0]                      ROW_WRITE_OUT,
   output logic [BA_WIDTH-1:0]                       BA_READ_OUT,
   output logic [COL_WIDTH-1:0]                      COL_READ_OUT,
   output logic [ROW_WIDTH-1:0]                      ROW_READ_OUT,
   output logic [BA_WIDTH+COL_WIDTH+ROW_WIDTH:0]     COUNT,
   output logic                                      FULL,
   output logic                                      EMPTY,
   output logic                                      OVERFLOW,
   output logic                                      UNDERFLOW
);

   localparam int ADDR_W = BA_WIDTH + COL_WIDTH + ROW_WIDTH;

   // STEP == 2^ADDR_W truncates to 0, which is exactly the modulo behaviour
   // wanted for a single-entry buffer.
   localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(longint'(STEP));
   localparam logic [ADDR_W:0]   CAPACITY = (ADDR_W+1)'((64'd1 << ADDR_W) / longint'(STEP));

   logic [ADDR_W-1:0] wp_reg, wp_next;
   logic [ADDR_W-1:0] rp_reg, rp_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              overflow_reg, overflow_next;
   logic              underflow_reg, underflow_next;
   logic              full, empty;

   assign full  = (count_reg == CAPACITY);
   assign empty = (count_reg == '0);

   always_comb begin
      wp_next        = wp_reg;
      rp_next        = rp_reg;
      count_next     = count_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;

      if (CLEAR) begin
         // Strobes coinciding with CLEAR are dropped on purpose.
         wp_next    = '0;
         rp_next    = '0;
         count_next = '0;
      end else begin
         unique case ({NEXT_WRITE, NEXT_READ})
            2'b10: begin
               if (!full) begin
                  wp_next    = wp_reg + STEP_INC;
                  count_next = count_reg + 1'b1;
               end else begin
                  overflow_next = 1'b1;
                  if (WRAP_MODE != 0) begin
                     // Overwrite oldest: both pointers move, count stays full.
                     wp_next = wp_reg + STEP_INC;
                     rp_next = rp_reg + STEP_INC;
                  end
               end
            end
            2'b01: begin
               if (!empty) begin
                  rp_next    = rp_reg + STEP_INC;
                  count_next = count_reg - 1'b1;
               end else begin
                  underflow_next = 1'b1;
               end
            end
            2'b11: begin
               if (empty) begin
                  // Nothing to read yet: the write lands, the read is refused.
                  wp_next        = wp_reg + STEP_INC;
                  count_next     = count_reg + 1'b1;
                  underflow_next = 1'b1;
               end else begin
                  // Balanced transfer; even when full the read frees the slot
                  // the write consumes, so this is not an overflow.
                  wp_next = wp_reg + STEP_INC;
                  rp_next = rp_reg + STEP_INC;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wp_reg        <= '0;
         rp_reg        <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wp_reg        <= wp_next;
         rp_reg        <= rp_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign {BA_WRITE_OUT, COL_WRITE_OUT, ROW_WRITE_OUT} = wp_reg;
   assign {BA_READ_OUT,  COL_READ_OUT,  ROW_READ_OUT}  = rp_reg;
   assign COUNT     = count_reg;
   assign FULL      = full;
   assign EMPTY     = empty;
   assign OVERFLOW  = overflow_reg;
   assign UNDERFLOW = underflow_reg;

endmodule

// File: tb/tb_sdram_address_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdram_address_sequencer
//
// Five instances of the sequencer with different parameter sets share one
// clock. Directed stimulus drives one instance at a time and pushes the
// hand-computed expected state into a scoreboard queue; a monitor on the
// falling edge pops each entry and compares it with the addressed instance.
//   0: defaults                      (ADDR_W=24, STEP=1, WRAP=1)
//   1: BA=1 COL=1 ROW=2, STEP=1, WRAP=1 (CAPACITY=16)
//   2: BA=1 COL=1 ROW=2, STEP=1, WRAP=0 (CAPACITY=16)
//   3: default widths, STEP=4, WRAP=1
//   4: BA=1 COL=1 ROW=2, STEP=4, WRAP=1 (CAPACITY=4)
// -----------------------------------------------------------------------------
module tb_sdram_address_sequencer;

   localparam int NDUT = 5;

   function automatic int f_ba(input int i);
      return (i == 0 || i == 3) ? 2 : 1;
   endfunction
   function automatic int f_col(input int i);
      return (i == 0 || i == 3) ? 9 : 1;
   endfunction
   function automatic int f_row(input int i);
      return (i == 0 || i == 3) ? 13 : 2;
   endfunction
   function automatic int f_step(input int i);
      return (i >= 3) ? 4 : 1;
   endfunction
   function automatic int f_wrap(input int i);
      return (i == 2) ? 0 : 1;
   endfunction

   logic CLK;
   logic [NDUT-1:0] rst, clr, nw, nr;

   logic [31:0]     wp_a  [NDUT];
   logic [31:0]     rp_a  [NDUT];
   logic [31:0]     cnt_a [NDUT];
   logic [NDUT-1:0] full_a, empty_a, ovf_a, unf_a;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      localparam int B = f_ba(gi);
      localparam int C = f_col(gi);
      localparam int R = f_row(gi);
      localparam int A = B + C + R;
      logic [B-1:0] ba_w, ba_r;
      logic [C-1:0] col_w, col_r;
      logic [R-1:0] row_w, row_r;
      logic [A:0]   cnt;
      logic         full, empty, ovf, unf;

      sdram_address_sequencer #(
         .BA_WIDTH (B),
         .ROW_WIDTH(R),
         .COL_WIDTH(C),
         .STEP     (f_step(gi)),
         .WRAP_MODE(f_wrap(gi))
      ) u_dut (
         .CLK          (CLK),
         .RESET        (rst[gi]),
         .CLEAR        (clr[gi]),
         .NEXT_WRITE   (nw[gi]),
         .NEXT_READ    (nr[gi]),
         .BA_WRITE_OUT (ba_w),
         .COL_WRITE_OUT(col_w),
         .ROW_WRITE_OUT(row_w),
         .BA_READ_OUT  (ba_r),
         .COL_READ_OUT (col_r),
         .ROW_READ_OUT (row_r),
         .COUNT        (cnt),
         .FULL         (full),
         .EMPTY        (empty),
         .OVERFLOW     (ovf),
         .UNDERFLOW    (unf)
      );

      assign wp_a[gi]    = 32'({ba_w, col_w, row_w});
      assign rp_a[gi]    = 32'({ba_r, col_r, row_r});
      assign cnt_a[gi]   = 32'(cnt);
      assign full_a[gi]  = full;
      assign empty_a[gi] = empty;
      assign ovf_a[gi]   = ovf;
      assign unf_a[gi]   = unf;
   end

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int          id;
      int unsigned wp;
      int unsigned rp;
      int unsigned cnt;
      bit          full;
      bit          empty;
      bit          ovf;
      bit          unf;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   // Monitor: compares one expected entry per falling edge.
   always @(negedge CLK) begin
      if (sb.size() > 0) begin
         exp_t e;
         int   i;
         e = sb.pop_front();
         i = e.id;
         checks++;
         if (wp_a[i] != e.wp || rp_a[i] != e.rp || cnt_a[i] != e.cnt ||
             full_a[i] != e.full || empty_a[i] != e.empty ||
             ovf_a[i] != e.ovf || unf_a[i] != e.unf) begin
            failures++;
            $display("FAIL %s dut%0d: got wp=%0d rp=%0d cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b; expected wp=%0d rp=%0d cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                     e.name, i, wp_a[i], rp_a[i], cnt_a[i], full_a[i], empty_a[i], ovf_a[i], unf_a[i],
                     e.wp, e.rp, e.cnt, e.full, e.empty, e.ovf, e.unf);
         end else begin
            $display("ok   %s dut%0d: wp=%0d rp=%0d cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                     e.name, i, wp_a[i], rp_a[i], cnt_a[i], full_a[i], empty_a[i], ovf_a[i], unf_a[i]);
         end
      end
   end

   // One clock cycle of stimulus on instance id; inputs change 1 time unit
   // after the rising edge so they never race the edge or the monitor.
   task automatic cyc(input int id, input bit w, input bit r, input bit c, input bit x);
      nw[id]  = w;
      nr[id]  = r;
      clr[id] = c;
      rst[id] = x;
      @(posedge CLK);
      #1;
      nw[id]  = 1'b0;
      nr[id]  = 1'b0;
      clr[id] = 1'b0;
      rst[id] = 1'b0;
   endtask

   task automatic writes(input int id, input int n);
      for (int k = 0; k < n; k++) cyc(id, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic expect_state(input int id, input int unsigned wp, input int unsigned rp,
                               input int unsigned cnt, input bit full, input bit empty,
                               input bit ovf, input bit unf, input string name);
      exp_t e;
      e.id = id; e.wp = wp; e.rp = rp; e.cnt = cnt;
      e.full = full; e.empty = empty; e.ovf = ovf; e.unf = unf; e.name = name;
      sb.push_back(e);
   endtask

   initial begin
      rst = '1; clr = '0; nw = '0; nr = '0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      rst = '0;

      // ---- dut0: defaults ---------------------------------------------------
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      expect_state(0, 0, 0, 0, 0, 1, 0, 0, "reset");
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0); expect_state(0, 1, 0, 1, 0, 0, 0, 0, "write1");
      cyc(0, 1, 0, 0, 0); expect_state(0, 2, 0, 2, 0, 0, 0, 0, "write2");
      cyc(0, 1, 0, 0, 0); expect_state(0, 3, 0, 3, 0, 0, 0, 0, "write3");
      cyc(0, 0, 0, 1, 0); expect_state(0, 0, 0, 0, 0, 1, 0, 0, "clear");
      cyc(0, 1, 1, 0, 0); expect_state(0, 1, 0, 1, 0, 0, 0, 1, "wr_rd_empty");
      writes(0, 4);       expect_state(0, 5, 0, 5, 0, 0, 0, 1, "count5");
      cyc(0, 1, 1, 0, 0); expect_state(0, 6, 1, 5, 0, 0, 0, 1, "wr_rd_mid");
      cyc(0, 1, 1, 1, 0); expect_state(0, 0, 0, 0, 0, 1, 0, 1, "clear_drops_strobes");
      writes(0, 8191);    expect_state(0, 8191, 0, 8191, 0, 0, 0, 1, "preload8191");
      // ROW field rolls over into COL bit 0: {BA=0, COL=1, ROW=0} = 8192.
      cyc(0, 1, 0, 0, 0); expect_state(0, 8192, 0, 8192, 0, 0, 0, 1, "row_carry");

      // ---- dut1: 16-entry, overwrite oldest ---------------------------------
      cyc(1, 0, 0, 0, 1); expect_state(1, 0, 0, 0, 0, 1, 0, 0, "reset_small");
      writes(1, 16);      expect_state(1, 0, 0, 16, 1, 0, 0, 0, "fill16_wrap");
      cyc(1, 1, 0, 0, 0); expect_state(1, 1, 1, 16, 1, 0, 1, 0, "overwrite_oldest");
      cyc(1, 0, 0, 0, 1); expect_state(1, 0, 0, 0, 0, 1, 0, 0, "reset_clears_ovf");
      writes(1, 16);
      cyc(1, 1, 1, 0, 0); expect_state(1, 1, 1, 16, 1, 0, 0, 0, "wr_rd_full_no_ovf");

      // ---- dut2: 16-entry, reject when full --------------------------------
      cyc(2, 0, 0, 0, 1);
      cyc(2, 0, 1, 0, 0); expect_state(2, 0, 0, 0, 0, 1, 0, 1, "read_empty");
      writes(2, 16);      expect_state(2, 0, 0, 16, 1, 0, 0, 1, "fill16_stop");
      cyc(2, 1, 0, 0, 0); expect_state(2, 0, 0, 16, 1, 0, 1, 1, "reject_full");
      cyc(2, 0, 1, 0, 0); expect_state(2, 0, 1, 15, 0, 0, 1, 1, "read_after_full");

      // ---- dut3: default widths, STEP=4 ------------------------------------
      cyc(3, 0, 0, 0, 1);
      cyc(3, 1, 0, 0, 0); expect_state(3, 4, 0, 1, 0, 0, 0, 0, "step4_w1");
      cyc(3, 1, 0, 0, 0); expect_state(3, 8, 0, 2, 0, 0, 0, 0, "step4_w2");
      cyc(3, 0, 1, 0, 0); expect_state(3, 8, 4, 1, 0, 0, 0, 0, "step4_read");

      // ---- dut4: 4-bit pointers, STEP=4, CAPACITY=4 ------------------------
      cyc(4, 0, 0, 0, 1);
      writes(4, 4);       expect_state(4, 0, 0, 4, 1, 0, 0, 0, "step4_fill");
      cyc(4, 1, 0, 0, 0); expect_state(4, 4, 4, 4, 1, 0, 1, 0, "step4_overflow");
      cyc(4, 0, 0, 1, 0); expect_state(4, 0, 0, 0, 0, 1, 1, 0, "clear_keeps_ovf");
      cyc(4, 0, 0, 0, 1); expect_state(4, 0, 0, 0, 0, 1, 0, 0, "reset_drops_ovf");

      // Let the monitor drain, bounded.
      for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge CLK);
      #1;
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
